// File: rtl/smoldvi_tmds_decode.sv
// TMDS lane decoder: aligns to control-symbol runs via bitslip requests, then decodes data/control words.
// One-cycle registered latency from d to q/c/den; no backpressure, one word is accepted every clk_pix.
module smoldvi_tmds_decode #(
  parameter int LOCK_COUNT     = 64,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_DELAY     = 8
) (
  input  logic       clk_pix,
  input  logic       rst_n_pix,
  input  logic       en,
  input  logic [9:0] d,
  output logic       bitslip,
  output logic       locked,
  output logic       err,
  output logic       den,
  output logic [7:0] q,
  output logic [1:0] c
);

  localparam int RUN_W   = $clog2(LOCK_COUNT) + 1;
  localparam int TMO_MAX = (SEARCH_TIMEOUT > SLIP_DELAY) ? SEARCH_TIMEOUT : SLIP_DELAY;
  localparam int TMO_W   = $clog2(TMO_MAX) + 1;

  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] SLIP_LAST = TMO_W'(SLIP_DELAY - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             slip_d, err_d;
  logic             is_ctrl;
  logic [1:0]       ctrl_code;
  logic [7:0]       dd, dec;
  logic             run_done;
  logic             out_live;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_code = 2'b00;
    case (d)
      CTRL_00: ctrl_code = 2'b00;
      CTRL_01: ctrl_code = 2'b01;
      CTRL_10: ctrl_code = 2'b10;
      CTRL_11: ctrl_code = 2'b11;
      default: is_ctrl   = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain selected by d[8].
  always_comb begin
    dd     = d[9] ? ~d[7:0] : d[7:0];
    dec    = 8'h00;
    dec[0] = dd[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = d[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
    end
  end

  assign run_done = is_ctrl && (run_q == RUN_LAST);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    slip_d  = 1'b0;
    err_d   = 1'b0;
    if (!is_ctrl) begin
      run_d = '0;
    end else if (run_q == RUN_FULL) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_ONE;
    end

    case (state_q)
      ST_SEARCH: begin
        tmo_d = tmo_q + TMO_ONE;
        if (run_done) begin
          state_d = ST_LOCKED;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_SLIP_WAIT;
          slip_d  = 1'b1;
          tmo_d   = '0;
          run_d   = '0;
        end
      end
      ST_SLIP_WAIT: begin
        run_d = '0;
        if (tmo_q == SLIP_LAST) begin
          state_d = ST_SEARCH;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ST_LOCKED: begin
        if (run_done) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_SEARCH;
          err_d   = 1'b1;
          tmo_d   = '0;
          run_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        tmo_d   = '0;
        run_d   = '0;
      end
    endcase

    if (!en) begin
      state_d = ST_SEARCH;
      tmo_d   = '0;
      run_d   = '0;
      slip_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // The lock-loss cycle already presents zeroed outputs alongside err.
  assign out_live = en && (state_q == ST_LOCKED) && !err_d;

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      state_q <= ST_SEARCH;
      tmo_q   <= '0;
      run_q   <= '0;
      bitslip <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      den     <= 1'b0;
      q       <= 8'h00;
      c       <= 2'b00;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      run_q   <= run_d;
      bitslip <= slip_d;
      err     <= err_d;
      locked  <= (state_d == ST_LOCKED);
      if (out_live) begin
        if (is_ctrl) begin
          den <= 1'b0;
          c   <= ctrl_code;
        end else begin
          den <= 1'b1;
          q   <= dec;
        end
      end else begin
        den <= 1'b0;
        q   <= 8'h00;
        c   <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_smoldvi_tmds_decode.sv
// Directed bench for smoldvi_tmds_decode: reference TMDS encoder, bitslip-aware deserialiser model.
module tb_smoldvi_tmds_decode;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;

  logic       clk_pix = 1'b0;
  logic       rst_n_pix;
  logic       en;
  logic [9:0] d;
  logic       bitslip, locked, err, den;
  logic [7:0] q;
  logic [1:0] c;

  int         ncmp = 0;
  int         nfail = 0;
  int         cyc = 0;
  int         nslip = 0;
  int         nerr = 0;
  int         lock_at = 0;
  int         off = 0;
  bit         honour = 1'b0;
  logic [9:0] prev_w = C00;
  int         slip_pos [8];

  smoldvi_tmds_decode dut (
    .clk_pix   (clk_pix),
    .rst_n_pix (rst_n_pix),
    .en        (en),
    .d         (d),
    .bitslip   (bitslip),
    .locked    (locked),
    .err       (err),
    .den       (den),
    .q         (q),
    .c         (c)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference transmitter: transition-minimising XOR/XNOR chain, optional inversion.
  function automatic logic use_xor(input logic [7:0] b);
    int n1;
    n1 = $countones(b);
    return !((n1 > 4) || (n1 == 4 && !b[0]));
  endfunction

  function automatic logic [9:0] enc_raw(input logic [7:0] b, input logic xr, input logic inv);
    logic [7:0] qm;
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = xr ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
    return inv ? {1'b1, xr, ~qm} : {1'b0, xr, qm};
  endfunction

  function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
    return enc_raw(b, use_xor(b), inv);
  endfunction

  // Drive one serial word through the deserialiser window; outputs are valid on return.
  task automatic send(input logic [9:0] w);
    logic [19:0] s;
    s = {w, prev_w};
    cyc++;
    d = s[(10-off) +: 10];
    prev_w = w;
    @(negedge clk_pix);
    if (bitslip === 1'b1) begin
      if (nslip < 8) slip_pos[nslip] = cyc;
      nslip++;
      if (honour) off = (off == 0) ? 9 : off - 1;
    end
    if (err === 1'b1) nerr++;
    if (locked === 1'b1 && lock_at == 0) lock_at = cyc;
  endtask

  task automatic send_n(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) send(w);
  endtask

  initial begin
    int         s0;
    logic [7:0] bj;
    rst_n_pix = 1'b0;
    en = 1'b0;
    d = 10'h000;
    repeat (3) @(negedge clk_pix);
    chk("rst_bitslip", {31'd0, bitslip}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_den", {31'd0, den}, 32'd0);
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_c", {30'd0, c}, 32'd0);
    rst_n_pix = 1'b1;
    en = 1'b1;

    // Aligned stream
    send_n(C00, 63);
    chk("align_locked_63", {31'd0, locked}, 32'd0);
    send(C00);
    chk("align_locked_64", {31'd0, locked}, 32'd1);
    send_n(C00, 96);
    chk("align_ctrl_den", {31'd0, den}, 32'd0);
    chk("align_ctrl_c", {30'd0, c}, 32'd0);
    for (int v = 0; v < 4; v++) begin
      send(enc_raw(8'hA5, v[1], v[0]));
      chk("a5_q", {24'd0, q}, 32'hA5);
      chk("a5_den", {31'd0, den}, 32'd1);
      chk("a5_c", {30'd0, c}, 32'd0);
    end
    chk("align_no_slip", nslip, 32'd0);

    // Sync recovery
    send(C11);
    chk("blank11_c", {30'd0, c}, 32'd3);
    chk("blank11_den", {31'd0, den}, 32'd0);
    send_n(C11, 79);
    for (int i = 0; i < 20; i++) begin
      bj = 8'(i * 37 + 5);
      send(enc(bj, i[0]));
      chk("sync_q", {24'd0, q}, {24'd0, bj});
      chk("sync_den", {31'd0, den}, 32'd1);
      chk("sync_c_held", {30'd0, c}, 32'd3);
    end
    send(C10);
    chk("sync10_c", {30'd0, c}, 32'd2);
    chk("sync10_den", {31'd0, den}, 32'd0);
    send_n(C10, 63);

    // Lock loss: the 64th C10 word refreshed lock, so the 2048th data word times out
    for (int j = 1; j < 2048; j++) begin
      bj = 8'(j);
      send(enc(bj, 1'b0));
    end
    chk("loss_pre_locked", {31'd0, locked}, 32'd1);
    chk("loss_pre_den", {31'd0, den}, 32'd1);
    chk("loss_pre_err", nerr, 32'd0);
    send(enc(8'h3C, 1'b1));
    chk("loss_err", {31'd0, err}, 32'd1);
    chk("loss_locked", {31'd0, locked}, 32'd0);
    chk("loss_den", {31'd0, den}, 32'd0);
    chk("loss_q", {24'd0, q}, 32'd0);
    chk("loss_c", {30'd0, c}, 32'd0);
    send(enc(8'h3C, 1'b0));
    chk("loss_err_pulse", {31'd0, err}, 32'd0);
    s0 = nslip;
    send_n(enc(8'h3C, 1'b0), 2046);
    chk("loss_no_early_slip", nslip - s0, 32'd0);
    send(enc(8'h3C, 1'b0));
    chk("loss_slip", {31'd0, bitslip}, 32'd1);
    chk("loss_err_once", nerr, 32'd1);

    // en=0 during SLIP_WAIT
    send(enc(8'h3C, 1'b0));
    chk("slip_one_cycle", {31'd0, bitslip}, 32'd0);
    send(enc(8'h3C, 1'b0));
    en = 1'b0;
    s0 = nslip;
    send_n(C00, 5);
    chk("en0_sw_locked", {31'd0, locked}, 32'd0);
    chk("en0_sw_den", {31'd0, den}, 32'd0);
    chk("en0_sw_c", {30'd0, c}, 32'd0);
    en = 1'b1;
    send_n(C00, 63);
    chk("en1_sw_locked_63", {31'd0, locked}, 32'd0);
    send(C00);
    chk("en1_sw_locked_64", {31'd0, locked}, 32'd1);

    // en=0 while LOCKED
    en = 1'b0;
    send(enc(8'h81, 1'b0));
    chk("en0_lk_locked", {31'd0, locked}, 32'd0);
    chk("en0_lk_err", {31'd0, err}, 32'd0);
    chk("en0_lk_den", {31'd0, den}, 32'd0);
    chk("en0_lk_q", {24'd0, q}, 32'd0);
    en = 1'b1;
    send_n(C00, 63);
    chk("en1_lk_locked_63", {31'd0, locked}, 32'd0);
    send(C00);
    chk("en1_lk_locked_64", {31'd0, locked}, 32'd1);
    chk("en_no_slip", nslip - s0, 32'd0);
    chk("en_no_err", nerr, 32'd1);

    // Exhaustive decode
    for (int b = 0; b < 256; b++) begin
      for (int v = 0; v < 2; v++) begin
        bj = 8'(b);
        send(enc(bj, v[0]));
        chk("exh_q", {24'd0, q}, {24'd0, bj});
        chk("exh_den", {31'd0, den}, 32'd1);
      end
    end

    // Asynchronous reset while locked
    #2 rst_n_pix = 1'b0;
    #1;
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_den", {31'd0, den}, 32'd0);
    chk("arst_q", {24'd0, q}, 32'd0);
    @(negedge clk_pix);
    rst_n_pix = 1'b1;

    // Reset mid-search restarts the timeout
    s0 = nslip;
    send_n(enc(8'h55, 1'b0), 1000);
    chk("srch_locked", {31'd0, locked}, 32'd0);
    #2 rst_n_pix = 1'b0;
    @(negedge clk_pix);
    rst_n_pix = 1'b1;
    send_n(enc(8'h55, 1'b0), 2047);
    chk("srch_no_slip", nslip - s0, 32'd0);
    send(enc(8'h55, 1'b0));
    chk("srch_slip", {31'd0, bitslip}, 32'd1);

    // Misaligned stream with bitslip honoured by the deserialiser model
    rst_n_pix = 1'b0;
    @(negedge clk_pix);
    cyc = 0;
    nslip = 0;
    lock_at = 0;
    off = 3;
    honour = 1'b1;
    prev_w = C00;
    rst_n_pix = 1'b1;
    send_n(C00, 6300);
    chk("mis_nslip", nslip, 32'd3);
    chk("mis_first_slip", slip_pos[0], 32'd2048);
    chk("mis_spacing_1", slip_pos[1] - slip_pos[0], 32'd2056);
    chk("mis_spacing_2", slip_pos[2] - slip_pos[1], 32'd2056);
    chk("mis_lock_at", lock_at, 32'd6232);
    chk("mis_locked", {31'd0, locked}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
